bcd_rtc_clock: RTL and testbench
================================

Name: bcd_rtc_clock

Overview:
Parametrised BCD hours/minutes/seconds real-time clock for display and timer paths. It generalises the fixed 12-hour counter in five ways:
- Selectable 12/24-hour mode.
- Prescaler on the enable input.
- Synchronous time/mode load with range checking.
- Armable alarm with a one-cycle hit pulse.
- Seconds-tick strobe.
Sits between a 1 Hz-class enable source and display/interrupt logic.

Parameters:
- TICK_DIV, 1, number of accepted ena pulses per one-second advance (legal range 1..65535).
- MODE24_RST, 0, hour mode after reset (0 = 12 h, 1 = 24 h).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- ena  in  1  enable pulse fed to the prescaler
- load  in  1  one-cycle request to load time and mode
- load_mode24  in  1  mode written on load
- load_hh  in  8  BCD hours to load
- load_mm  in  8  BCD minutes to load
- load_ss  in  8  BCD seconds to load
- load_pm  in  1  PM flag to load (used in 12 h mode only)
- alarm_wr  in  1  one-cycle write of alarm registers
- alarm_arm  in  1  arm value written on alarm_wr
- alarm_hh  in  8  BCD alarm hour, same encoding as the current mode
- alarm_mm  in  8  BCD alarm minute
- alarm_pm  in  1  alarm PM flag (12 h mode only)
- mode24  out  1  current hour mode
- pm  out  1  PM flag
- hh  out  8  BCD hours
- mm  out  8  BCD minutes
- ss  out  8  BCD seconds
- sec_tick  out  1  one-cycle pulse, high in the cycle after each advance
- load_err  out  1  one-cycle pulse on a rejected load
- alarm_hit  out  1  one-cycle pulse on an alarm match

Behaviour:

Reset (synchronous, highest priority):
- mode24=MODE24_RST, mm=ss=8'h00, pm=0.
- hh=8'h12 in 12 h mode, 8'h00 in 24 h mode.
- Prescaler=0; alarm registers cleared and disarmed.
- sec_tick=load_err=alarm_hit=0.

Prescaler:
- Counts accepted ena pulses, 0..TICK_DIV-1.
- An advance occurs on an ena pulse while the count equals TICK_DIV-1; the count then wraps to 0.
- ena low: everything holds.

Advance:
- ss digits count 0-9 / 0-5. Carry into mm at :59, same digit rule. Carry into hh at mm:ss=59:59.
- 12 h mode: hours run 12,01,…,11. 11:59:59 -> 12:00:00 with pm toggled. 12:59:59 -> 01:00:00 with pm unchanged.
- 24 h mode: hours run 00..23; 23:59:59 -> 00:00:00. pm is always driven to (hh>=12) of the new value.

Load (priority over advance in the same cycle):
- Validity rules: every nibble must be ≤9, mm/ss ≤ 8'h59, and hh must be in range — 01..12 if load_mode24=0, 00..23 if load_mode24=1.
- Valid load: writes mode24, hh, mm, ss and pm (pm is computed from hh in 24 h mode). Prescaler clears to 0. No advance and no sec_tick in that cycle.
- Invalid load: all state unchanged, including the prescaler. No advance that cycle. load_err pulses the following cycle.

Alarm registers:
- alarm_wr writes arm, hh, mm and pm. Values are not range-checked.
- A mode change does not convert the alarm values; software rewrites the alarm after changing mode.

Alarm hit:
- alarm_hit is a registered pulse in the cycle after an advance whose new value has ss=00, mm=alarm_mm and hh=alarm_hh.
- pm must also equal alarm_pm in 12 h mode; pm is ignored in 24 h mode.
- Requires the alarm to be armed at that advance.
- A load never raises alarm_hit. The alarm stays armed after a hit.

Simultaneous events:
- alarm_wr in the same cycle as an advance: the match uses the old alarm registers.
- reset mid-operation discards any pending pulses.

Outputs are all registered; no combinational paths from inputs to outputs.

Decomposition:
Package rtc_pkg:
- BCD constants: H12_MAX=8'h12, H24_MAX=8'h23, MS_MAX=8'h59.
- Functions bcd_valid(8b,max) and hh_is_pm_24(8b).
- Prescaler width derived as $clog2(TICK_DIV+1).

Sub-module bcd_digit_pair:
- Two-digit BCD counter with inputs inc and max, and output carry_out.
- Instantiated for ss and mm. Hours stay in the top level because of the 12/24 h wrap rules.

Test Plan:
1. Reset with MODE24_RST=0, TICK_DIV=1; 86400 ena pulses -> one full pm cycle. Check 11:59:59 AM -> 12:00:00 PM (pm=1), 12:59:59 -> 01:00:00, and final state 12:00:00 AM.
2. Load mode24=1, 23:59:58; two ena -> 23:59:59 pm=1, then 00:00:00 pm=0. At 11:59:59 -> 12:00:00, pm rises to 1.
3. TICK_DIV=4: ena on 7 cycles -> exactly one advance after the 4th pulse, with sec_tick high one cycle later. The 3 further pulses leave the count at 3.
4. Load hh=8'h13 with mode24=0 -> load_err pulse, state unchanged. Load 8'h1A -> rejected. Load with an ena advance in the same cycle -> loaded value exactly, no sec_tick.
5. Alarm armed 07:30 AM; load 07:29:59 AM; one advance -> alarm_hit=1 for one cycle. Repeat at 07:30 PM -> no hit. Disarmed -> no hit.
6. Reset asserted mid-count with the prescaler at 2 and alarm_hit pending -> 12:00:00 AM, all pulses low, prescaler 0, alarm disarmed.

Source files
------------

// File: rtl/rtc_pkg.sv
// rtc_pkg: BCD limits and helpers shared by the real-time clock files
package rtc_pkg;
    localparam logic [7:0] H12_MAX = 8'h12;
    localparam logic [7:0] H24_MAX = 8'h23;
    localparam logic [7:0] MS_MAX  = 8'h59;

    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= max;
    endfunction

    function automatic logic hh_is_pm_24(input logic [7:0] h);
        return h >= 8'h12;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
    endfunction

    function automatic int presc_w(input int div);
        return $clog2(div + 1);
    endfunction
endpackage

// File: rtl/bcd_digit_pair.sv
// bcd_digit_pair: two-digit BCD counter wrapping to 00 after max, with load
module bcd_digit_pair
    import rtc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       ld,
    input  logic [7:0] ld_val,
    input  logic [7:0] max,
    output logic [7:0] q,
    output logic [7:0] nxt,
    output logic       carry_out
);
    assign carry_out = inc && q == max;
    assign nxt = ld ? ld_val : carry_out ? 8'h00 : inc ? bcd_inc(q) : q;

    always_ff @(posedge clk)
        q <= reset ? 8'h00 : nxt;
endmodule

// File: rtl/bcd_rtc_clock.sv
// bcd_rtc_clock: BCD hh:mm:ss clock with 12/24 h mode, prescaler, checked load and alarm
module bcd_rtc_clock
    import rtc_pkg::*;
#(
    parameter int TICK_DIV   = 1,
    parameter bit MODE24_RST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load,
    input  logic       load_mode24,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    input  logic       alarm_wr,
    input  logic       alarm_arm,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    output logic       mode24,
    output logic       pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       sec_tick,
    output logic       load_err,
    output logic       alarm_hit
);
    localparam int PW = presc_w(TICK_DIV);

    logic [PW-1:0] presc;
    logic          load_ok, adv, ss_c, mm_c, pm_n, hit_n;
    logic [7:0]    ss_n, mm_n, hh_n, hh_wrap;
    logic          al_arm, al_pm;
    logic [7:0]    al_hh, al_mm;

    assign load_ok = load && bcd_valid(load_mm, MS_MAX) && bcd_valid(load_ss, MS_MAX)
        && (load_mode24 ? bcd_valid(load_hh, H24_MAX)
                        : bcd_valid(load_hh, H12_MAX) && load_hh != 8'h00);
    assign adv = ena && !load && presc == PW'(TICK_DIV - 1);

    bcd_digit_pair u_ss (
        .clk(clk), .reset(reset), .inc(adv), .ld(load_ok), .ld_val(load_ss),
        .max(MS_MAX), .q(ss), .nxt(ss_n), .carry_out(ss_c)
    );

    bcd_digit_pair u_mm (
        .clk(clk), .reset(reset), .inc(ss_c), .ld(load_ok), .ld_val(load_mm),
        .max(MS_MAX), .q(mm), .nxt(mm_n), .carry_out(mm_c)
    );

    // 12 h hours run 12,01..11; pm flips only on the 11 -> 12 step
    always_comb begin
        hh_wrap = mode24 ? (hh == H24_MAX ? 8'h00 : bcd_inc(hh))
                         : (hh == H12_MAX ? 8'h01 : bcd_inc(hh));
        hh_n    = load_ok ? load_hh : mm_c ? hh_wrap : hh;
        pm_n    = load_ok ? (load_mode24 ? hh_is_pm_24(load_hh) : load_pm)
                : !mm_c   ? pm
                : mode24  ? hh_is_pm_24(hh_wrap) : pm ^ (hh == 8'h11);
        hit_n   = adv && al_arm && ss_n == 8'h00 && mm_n == al_mm && hh_n == al_hh
                && (mode24 || pm_n == al_pm);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode24    <= MODE24_RST;
            hh        <= MODE24_RST ? 8'h00 : H12_MAX;
            pm        <= 1'b0;
            presc     <= '0;
            al_arm    <= 1'b0;
            al_pm     <= 1'b0;
            al_hh     <= 8'h00;
            al_mm     <= 8'h00;
            sec_tick  <= 1'b0;
            load_err  <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            if (load_ok)
                mode24 <= load_mode24;
            hh    <= hh_n;
            pm    <= pm_n;
            presc <= load_ok ? '0 : (ena && !load) ? (adv ? '0 : presc + 1'b1) : presc;
            if (alarm_wr) begin
                al_arm <= alarm_arm;
                al_pm  <= alarm_pm;
                al_hh  <= alarm_hh;
                al_mm  <= alarm_mm;
            end
            sec_tick  <= adv;
            load_err  <= load && !load_ok;
            alarm_hit <= hit_n;
        end
    end
endmodule

// File: tb/tb_bcd_rtc_clock.sv
// tb_bcd_rtc_clock: directed vectors into a scoreboard queue; a negedge monitor pops and compares
module tb_bcd_rtc_clock;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b0, load = 1'b0, load_mode24 = 1'b0, load_pm = 1'b0;
    logic [7:0] load_hh = 8'h00, load_mm = 8'h00, load_ss = 8'h00;
    logic       alarm_wr = 1'b0, alarm_arm = 1'b0, alarm_pm = 1'b0;
    logic [7:0] alarm_hh = 8'h00, alarm_mm = 8'h00;
    logic       mode24, pm, sec_tick, load_err, alarm_hit;
    logic [7:0] hh, mm, ss;
    logic       probe = 1'b0;

    typedef struct {
        string       n;
        logic [28:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [28:0] a;
    int          n_tests = 0;
    int          n_fail = 0;

    bcd_rtc_clock #(.TICK_DIV(4), .MODE24_RST(1'b0)) dut (
        .clk(clk), .reset(reset), .ena(ena), .load(load), .load_mode24(load_mode24),
        .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss), .load_pm(load_pm),
        .alarm_wr(alarm_wr), .alarm_arm(alarm_arm), .alarm_hh(alarm_hh),
        .alarm_mm(alarm_mm), .alarm_pm(alarm_pm), .mode24(mode24), .pm(pm),
        .hh(hh), .mm(mm), .ss(ss), .sec_tick(sec_tick), .load_err(load_err),
        .alarm_hit(alarm_hit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Every probed cycle and every output pulse consumes exactly one expectation
    always @(negedge clk) begin
        if (probe || sec_tick === 1'b1 || load_err === 1'b1 || alarm_hit === 1'b1) begin
            n_tests++;
            a = {mode24, pm, hh, mm, ss, sec_tick, load_err, alarm_hit};
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got m24=%b pm=%b %h:%h:%h tick=%b err=%b hit=%b, required no output",
                         a[28], a[27], a[26:19], a[18:11], a[10:3], a[2], a[1], a[0]);
            end else begin
                e = sb.pop_front();
                if (a !== e.v) begin
                    n_fail++;
                    $display("FAIL %s: got m24=%b pm=%b %h:%h:%h tick=%b err=%b hit=%b, required m24=%b pm=%b %h:%h:%h tick=%b err=%b hit=%b",
                             e.n, a[28], a[27], a[26:19], a[18:11], a[10:3], a[2], a[1], a[0],
                             e.v[28], e.v[27], e.v[26:19], e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
        end
    end

    task automatic cyc(input bit chk);
        @(posedge clk);
        #1;
        ena = 1'b0;
        load = 1'b0;
        alarm_wr = 1'b0;
        reset = 1'b0;
        probe = chk;
    endtask

    task automatic expect_now(input string n, input bit m24, input bit p, input logic [7:0] h,
                              input logic [7:0] m, input logic [7:0] s, input bit st,
                              input bit le, input bit ah);
        exp_t x;
        x.n = n;
        x.v = {m24, p, h, m, s, st, le, ah};
        sb.push_back(x);
        cyc(1'b1);
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            ena = 1'b1;
            cyc(1'b0);
        end
    endtask

    task automatic adv(input string n, input bit m24, input bit p, input logic [7:0] h,
                       input logic [7:0] m, input logic [7:0] s, input bit ah);
        pulses(3);
        ena = 1'b1;
        expect_now(n, m24, p, h, m, s, 1'b1, 1'b0, ah);
    endtask

    task automatic do_load(input bit m24, input logic [7:0] h, input logic [7:0] m,
                           input logic [7:0] s, input bit p, input bit with_ena);
        load = 1'b1;
        load_mode24 = m24;
        load_hh = h;
        load_mm = m;
        load_ss = s;
        load_pm = p;
        ena = with_ena;
    endtask

    task automatic set_alarm(input bit arm, input logic [7:0] h, input logic [7:0] m, input bit p);
        alarm_wr = 1'b1;
        alarm_arm = arm;
        alarm_hh = h;
        alarm_mm = m;
        alarm_pm = p;
    endtask

    initial begin
        reset = 1'b1;
        cyc(1'b0);
        reset = 1'b1;
        expect_now("reset", 0, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0);

        do_load(0, 8'h11, 8'h59, 8'h58, 0, 0);
        expect_now("ld_115958", 0, 0, 8'h11, 8'h59, 8'h58, 0, 0, 0);
        adv("am_115959", 0, 0, 8'h11, 8'h59, 8'h59, 0);
        adv("noon", 0, 1, 8'h12, 8'h00, 8'h00, 0);
        do_load(0, 8'h12, 8'h59, 8'h59, 1, 0);
        expect_now("ld_125959", 0, 1, 8'h12, 8'h59, 8'h59, 0, 0, 0);
        adv("one_pm", 0, 1, 8'h01, 8'h00, 8'h00, 0);
        do_load(0, 8'h11, 8'h59, 8'h59, 1, 0);
        expect_now("ld_pm_115959", 0, 1, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        adv("midnight_12h", 0, 0, 8'h12, 8'h00, 8'h00, 0);

        do_load(1, 8'h23, 8'h59, 8'h58, 0, 0);
        expect_now("ld24_235958", 1, 1, 8'h23, 8'h59, 8'h58, 0, 0, 0);
        adv("s24_235959", 1, 1, 8'h23, 8'h59, 8'h59, 0);
        adv("midnight_24h", 1, 0, 8'h00, 8'h00, 8'h00, 0);
        do_load(1, 8'h11, 8'h59, 8'h59, 1, 0);
        expect_now("ld24_pm_ignored", 1, 0, 8'h11, 8'h59, 8'h59, 0, 0, 0);
        adv("noon_24h", 1, 1, 8'h12, 8'h00, 8'h00, 0);
        do_load(1, 8'h09, 8'h59, 8'h59, 0, 0);
        expect_now("ld24_095959", 1, 0, 8'h09, 8'h59, 8'h59, 0, 0, 0);
        adv("digit_carry_10h", 1, 0, 8'h10, 8'h00, 8'h00, 0);

        do_load(0, 8'h05, 8'h00, 8'h00, 0, 0);
        expect_now("ld_050000", 0, 0, 8'h05, 8'h00, 8'h00, 0, 0, 0);
        pulses(3);
        ena = 1'b1;
        expect_now("presc_4th", 0, 0, 8'h05, 8'h00, 8'h01, 1, 0, 0);
        ena = 1'b1;
        expect_now("tick_one_cycle", 0, 0, 8'h05, 8'h00, 8'h01, 0, 0, 0);
        pulses(2);
        ena = 1'b1;
        expect_now("presc_at_3", 0, 0, 8'h05, 8'h00, 8'h02, 1, 0, 0);

        pulses(2);
        do_load(0, 8'h13, 8'h00, 8'h00, 0, 1);
        expect_now("err_hh13", 0, 0, 8'h05, 8'h00, 8'h02, 0, 1, 0);
        do_load(0, 8'h1A, 8'h00, 8'h00, 0, 1);
        expect_now("err_hh1A", 0, 0, 8'h05, 8'h00, 8'h02, 0, 1, 0);
        do_load(1, 8'h24, 8'h00, 8'h00, 0, 1);
        expect_now("err_hh24", 0, 0, 8'h05, 8'h00, 8'h02, 0, 1, 0);
        do_load(0, 8'h00, 8'h00, 8'h00, 0, 1);
        expect_now("err_hh00_12h", 0, 0, 8'h05, 8'h00, 8'h02, 0, 1, 0);
        do_load(0, 8'h05, 8'h60, 8'h00, 0, 1);
        expect_now("err_mm60", 0, 0, 8'h05, 8'h00, 8'h02, 0, 1, 0);
        do_load(0, 8'h05, 8'h00, 8'h5A, 0, 1);
        expect_now("err_ss5A", 0, 0, 8'h05, 8'h00, 8'h02, 0, 1, 0);
        pulses(1);
        ena = 1'b1;
        expect_now("presc_kept_on_err", 0, 0, 8'h05, 8'h00, 8'h03, 1, 0, 0);
        pulses(3);
        do_load(0, 8'h08, 8'h15, 8'h30, 1, 1);
        expect_now("load_beats_adv", 0, 1, 8'h08, 8'h15, 8'h30, 0, 0, 0);
        adv("presc_cleared", 0, 1, 8'h08, 8'h15, 8'h31, 0);

        set_alarm(1, 8'h07, 8'h30, 0);
        cyc(1'b0);
        do_load(0, 8'h07, 8'h29, 8'h59, 0, 0);
        expect_now("ld_072959am", 0, 0, 8'h07, 8'h29, 8'h59, 0, 0, 0);
        adv("alarm_hit_am", 0, 0, 8'h07, 8'h30, 8'h00, 1);
        expect_now("alarm_one_cycle", 0, 0, 8'h07, 8'h30, 8'h00, 0, 0, 0);
        do_load(0, 8'h07, 8'h29, 8'h59, 1, 0);
        expect_now("ld_072959pm", 0, 1, 8'h07, 8'h29, 8'h59, 0, 0, 0);
        adv("alarm_pm_miss", 0, 1, 8'h07, 8'h30, 8'h00, 0);
        set_alarm(0, 8'h07, 8'h30, 0);
        do_load(0, 8'h07, 8'h29, 8'h59, 0, 0);
        expect_now("ld_disarmed", 0, 0, 8'h07, 8'h29, 8'h59, 0, 0, 0);
        adv("alarm_disarmed", 0, 0, 8'h07, 8'h30, 8'h00, 0);
        set_alarm(1, 8'h07, 8'h30, 0);
        do_load(0, 8'h07, 8'h29, 8'h59, 0, 0);
        expect_now("ld_rearmed", 0, 0, 8'h07, 8'h29, 8'h59, 0, 0, 0);
        pulses(3);
        ena = 1'b1;
        set_alarm(0, 8'h07, 8'h30, 0);
        expect_now("alarm_wr_same_cycle", 0, 0, 8'h07, 8'h30, 8'h00, 1, 0, 1);
        set_alarm(1, 8'h19, 8'h00, 0);
        do_load(1, 8'h18, 8'h59, 8'h59, 0, 0);
        expect_now("ld24_185959", 1, 1, 8'h18, 8'h59, 8'h59, 0, 0, 0);
        adv("alarm_24h_pm_ignored", 1, 1, 8'h19, 8'h00, 8'h00, 1);

        do_load(1, 8'h18, 8'h59, 8'h59, 0, 0);
        expect_now("ld24_pre_reset", 1, 1, 8'h18, 8'h59, 8'h59, 0, 0, 0);
        pulses(3);
        ena = 1'b1;
        reset = 1'b1;
        expect_now("reset_over_hit", 0, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0);
        adv("after_reset_presc0", 0, 0, 8'h12, 8'h00, 8'h01, 0);
        pulses(2);
        reset = 1'b1;
        expect_now("reset_presc2", 0, 0, 8'h12, 8'h00, 8'h00, 0, 0, 0);
        adv("presc2_cleared", 0, 0, 8'h12, 8'h00, 8'h01, 0);
        do_load(1, 8'h23, 8'h59, 8'h59, 0, 0);
        expect_now("ld24_235959", 1, 1, 8'h23, 8'h59, 8'h59, 0, 0, 0);
        adv("alarm_cleared_by_reset", 1, 0, 8'h00, 8'h00, 8'h00, 0);

        repeat (3) cyc(1'b0);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d expectations left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
